// File: rtl/lc4_wb_scoreboard_ss.sv
// Writeback register stage plus per-register pending-write scoreboard for the
// dual-pipe LC4 register file; produces in-order issue stalls for decode.
module lc4_wb_scoreboard_ss #(
  parameter int n  = 16,
  parameter int CW = 2
) (
  input  logic         clk,
  input  logic         gwe,
  input  logic         rst,
  input  logic         i_issue_A,
  input  logic         i_issue_we_A,
  input  logic [2:0]   i_issue_rd_A,
  input  logic         i_rs_re_A,
  input  logic         i_rt_re_A,
  input  logic [2:0]   i_rs_A,
  input  logic [2:0]   i_rt_A,
  input  logic         i_issue_B,
  input  logic         i_issue_we_B,
  input  logic [2:0]   i_issue_rd_B,
  input  logic         i_rs_re_B,
  input  logic         i_rt_re_B,
  input  logic [2:0]   i_rs_B,
  input  logic [2:0]   i_rt_B,
  output logic         o_stall_A,
  output logic         o_stall_B,
  input  logic         i_wb_valid_A,
  input  logic [2:0]   i_wb_rd_A,
  input  logic [n-1:0] i_wb_data_A,
  input  logic         i_wb_valid_B,
  input  logic [2:0]   i_wb_rd_B,
  input  logic [n-1:0] i_wb_data_B,
  output logic         o_rd_we_A,
  output logic [2:0]   o_rd_A,
  output logic [n-1:0] o_wdata_A,
  output logic         o_rd_we_B,
  output logic [2:0]   o_rd_B,
  output logic [n-1:0] o_wdata_B,
  output logic         o_err
);

  localparam logic [CW:0] MAXV = {1'b0, {CW{1'b1}}};

  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  logic [CW-1:0] eff   [8];
  logic [1:0]    ret_cnt [8];
  logic          err_d;
  logic          inc_A, inc_B;
  logic          haz_A, haz_B, ovf_A, ovf_B, dep_B;
  logic [CW:0]   eff_B_ext;

  // eff[] discounts writes landing on the ports now: the register file bypasses them.
  always_comb begin
    for (int unsigned r = 0; r < 8; r++) begin
      ret_cnt[r] = {1'b0, o_rd_we_A && (o_rd_A == r[2:0])}
                 + {1'b0, o_rd_we_B && (o_rd_B == r[2:0])};
      if ((CW+1)'(ret_cnt[r]) > {1'b0, cnt_q[r]})
        eff[r] = '0;
      else
        eff[r] = CW'({1'b0, cnt_q[r]} - (CW+1)'(ret_cnt[r]));
    end
  end

  always_comb begin
    haz_A = (i_rs_re_A && (eff[i_rs_A] != '0)) || (i_rt_re_A && (eff[i_rt_A] != '0));
    ovf_A = i_issue_we_A && (eff[i_issue_rd_A] == '1);
    o_stall_A = i_issue_A && (haz_A || ovf_A);
    inc_A = i_issue_A && i_issue_we_A && !o_stall_A;

    haz_B = (i_rs_re_B && (eff[i_rs_B] != '0)) || (i_rt_re_B && (eff[i_rt_B] != '0));
    dep_B = i_issue_A && i_issue_we_A &&
            ((i_rs_re_B && (i_issue_rd_A == i_rs_B)) || (i_rt_re_B && (i_issue_rd_A == i_rt_B)));
    eff_B_ext = {1'b0, eff[i_issue_rd_B]}
              + {{CW{1'b0}}, inc_A && (i_issue_rd_A == i_issue_rd_B)};
    ovf_B = i_issue_we_B && (eff_B_ext >= MAXV);
    o_stall_B = i_issue_B && (o_stall_A || haz_B || dep_B || ovf_B);
    inc_B = i_issue_B && i_issue_we_B && !o_stall_B;
  end

  always_comb begin
    logic [1:0]  inc;
    logic [CW:0] sum;
    logic [CW:0] ret;
    err_d = o_err;
    cnt_d = cnt_q;
    for (int unsigned r = 0; r < 8; r++) begin
      inc = {1'b0, inc_A && (i_issue_rd_A == r[2:0])}
          + {1'b0, inc_B && (i_issue_rd_B == r[2:0])};
      sum = {1'b0, cnt_q[r]} + (CW+1)'(inc);
      ret = (CW+1)'(ret_cnt[r]);
      if (ret > {1'b0, cnt_q[r]}) err_d = 1'b1;
      // Underflow clamps at zero; overflow saturates.
      if (ret >= sum) begin
        cnt_d[r] = '0;
      end else if ((sum - ret) > MAXV) begin
        cnt_d[r] = '1;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CW'(sum - ret);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst) begin
        cnt_q     <= '{default: '0};
        o_err     <= 1'b0;
        o_rd_we_A <= 1'b0;
        o_rd_A    <= '0;
        o_wdata_A <= '0;
        o_rd_we_B <= 1'b0;
        o_rd_B    <= '0;
        o_wdata_B <= '0;
      end else begin
        cnt_q     <= cnt_d;
        o_err     <= err_d;
        o_rd_we_A <= i_wb_valid_A;
        o_rd_A    <= i_wb_rd_A;
        o_wdata_A <= i_wb_data_A;
        o_rd_we_B <= i_wb_valid_B;
        o_rd_B    <= i_wb_rd_B;
        o_wdata_B <= i_wb_data_B;
      end
    end
  end

endmodule

// File: tb/tb_lc4_wb_scoreboard_ss.sv
// Directed and randomized checks of lc4_wb_scoreboard_ss against an integer
// pending-count reference model.
module tb_lc4_wb_scoreboard_ss;

  localparam int N    = 16;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic gwe, rst;
  logic i_issue_A, i_issue_we_A, i_rs_re_A, i_rt_re_A;
  logic [2:0] i_issue_rd_A, i_rs_A, i_rt_A;
  logic i_issue_B, i_issue_we_B, i_rs_re_B, i_rt_re_B;
  logic [2:0] i_issue_rd_B, i_rs_B, i_rt_B;
  logic o_stall_A, o_stall_B;
  logic i_wb_valid_A, i_wb_valid_B;
  logic [2:0] i_wb_rd_A, i_wb_rd_B;
  logic [N-1:0] i_wb_data_A, i_wb_data_B;
  logic o_rd_we_A, o_rd_we_B;
  logic [2:0] o_rd_A, o_rd_B;
  logic [N-1:0] o_wdata_A, o_wdata_B;
  logic o_err;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes per register, writes not yet handed to
  // writeback, and the write-port contents as the register file sees them.
  int pend [8];
  int outst [8];
  bit m_we_A, m_we_B, m_err;
  int m_rd_A, m_rd_B;
  int m_wd_A, m_wd_B;

  lc4_wb_scoreboard_ss #(.n(N), .CW(2)) dut (
    .clk(clk), .gwe(gwe), .rst(rst),
    .i_issue_A(i_issue_A), .i_issue_we_A(i_issue_we_A), .i_issue_rd_A(i_issue_rd_A),
    .i_rs_re_A(i_rs_re_A), .i_rt_re_A(i_rt_re_A), .i_rs_A(i_rs_A), .i_rt_A(i_rt_A),
    .i_issue_B(i_issue_B), .i_issue_we_B(i_issue_we_B), .i_issue_rd_B(i_issue_rd_B),
    .i_rs_re_B(i_rs_re_B), .i_rt_re_B(i_rt_re_B), .i_rs_B(i_rs_B), .i_rt_B(i_rt_B),
    .o_stall_A(o_stall_A), .o_stall_B(o_stall_B),
    .i_wb_valid_A(i_wb_valid_A), .i_wb_rd_A(i_wb_rd_A), .i_wb_data_A(i_wb_data_A),
    .i_wb_valid_B(i_wb_valid_B), .i_wb_rd_B(i_wb_rd_B), .i_wb_data_B(i_wb_data_B),
    .o_rd_we_A(o_rd_we_A), .o_rd_A(o_rd_A), .o_wdata_A(o_wdata_A),
    .o_rd_we_B(o_rd_we_B), .o_rd_B(o_rd_B), .o_wdata_B(o_wdata_B),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    gwe = 1'b1; rst = 1'b0;
    i_issue_A = 0; i_issue_we_A = 0; i_issue_rd_A = 0; i_rs_re_A = 0; i_rt_re_A = 0; i_rs_A = 0; i_rt_A = 0;
    i_issue_B = 0; i_issue_we_B = 0; i_issue_rd_B = 0; i_rs_re_B = 0; i_rt_re_B = 0; i_rs_B = 0; i_rt_B = 0;
    i_wb_valid_A = 0; i_wb_rd_A = 0; i_wb_data_A = 0;
    i_wb_valid_B = 0; i_wb_rd_B = 0; i_wb_data_B = 0;
  endtask

  // Inputs are set just after a falling edge; compare, clock, advance model.
  task automatic step();
    int eff [8];
    int ret, inc, nv, eb;
    bit st_a, st_b, inc_a, inc_b, hz_b, dep;
    #1;
    for (int r = 0; r < 8; r++) begin
      ret = ((m_we_A && m_rd_A == r) ? 1 : 0) + ((m_we_B && m_rd_B == r) ? 1 : 0);
      eff[r] = (pend[r] > ret) ? pend[r] - ret : 0;
    end
    st_a = i_issue_A && ((i_rs_re_A && eff[i_rs_A] != 0) || (i_rt_re_A && eff[i_rt_A] != 0) ||
                         (i_issue_we_A && eff[i_issue_rd_A] == MAXC));
    inc_a = i_issue_A && i_issue_we_A && !st_a;
    hz_b = (i_rs_re_B && eff[i_rs_B] != 0) || (i_rt_re_B && eff[i_rt_B] != 0);
    dep = i_issue_A && i_issue_we_A &&
          ((i_rs_re_B && i_issue_rd_A == i_rs_B) || (i_rt_re_B && i_issue_rd_A == i_rt_B));
    eb = eff[i_issue_rd_B] + ((inc_a && i_issue_rd_A == i_issue_rd_B) ? 1 : 0);
    st_b = i_issue_B && (st_a || hz_b || dep || (i_issue_we_B && eb >= MAXC));
    inc_b = i_issue_B && i_issue_we_B && !st_b;

    check("stall_A", o_stall_A, st_a);
    check("stall_B", o_stall_B, st_b);
    check("we_A", o_rd_we_A, m_we_A);
    check("rd_A", o_rd_A, m_rd_A);
    check("wdata_A", o_wdata_A, m_wd_A);
    check("we_B", o_rd_we_B, m_we_B);
    check("rd_B", o_rd_B, m_rd_B);
    check("wdata_B", o_wdata_B, m_wd_B);
    check("err", o_err, m_err);

    @(posedge clk);
    if (gwe) begin
      if (rst) begin
        for (int r = 0; r < 8; r++) begin pend[r] = 0; outst[r] = 0; end
        m_err = 0; m_we_A = 0; m_rd_A = 0; m_wd_A = 0; m_we_B = 0; m_rd_B = 0; m_wd_B = 0;
      end else begin
        for (int r = 0; r < 8; r++) begin
          ret = ((m_we_A && m_rd_A == r) ? 1 : 0) + ((m_we_B && m_rd_B == r) ? 1 : 0);
          inc = ((inc_a && i_issue_rd_A == r) ? 1 : 0) + ((inc_b && i_issue_rd_B == r) ? 1 : 0);
          if (ret > pend[r]) m_err = 1;
          nv = pend[r] + inc - ret;
          if (nv < 0) nv = 0;
          if (nv > MAXC) begin nv = MAXC; m_err = 1; end
          pend[r] = nv;
          outst[r] += inc;
        end
        if (i_wb_valid_A && outst[i_wb_rd_A] > 0) outst[i_wb_rd_A]--;
        if (i_wb_valid_B && outst[i_wb_rd_B] > 0) outst[i_wb_rd_B]--;
        m_we_A = i_wb_valid_A; m_rd_A = i_wb_rd_A; m_wd_A = i_wb_data_A;
        m_we_B = i_wb_valid_B; m_rd_B = i_wb_rd_B; m_wd_B = i_wb_data_B;
      end
    end
    @(negedge clk);
  endtask

  // Present up to two writebacks chosen from writes that are still owed.
  task automatic pick_writebacks();
    int avail [8];
    int s;
    for (int r = 0; r < 8; r++) avail[r] = outst[r];
    if ($urandom_range(0, 1) == 1) begin
      s = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++) begin
        if (avail[(s + k) % 8] > 0) begin
          i_wb_valid_A = 1; i_wb_rd_A = 3'((s + k) % 8); i_wb_data_A = N'($urandom);
          avail[(s + k) % 8]--;
          break;
        end
      end
    end
    if ($urandom_range(0, 1) == 1) begin
      s = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++) begin
        if (avail[(s + k) % 8] > 0) begin
          i_wb_valid_B = 1; i_wb_rd_B = 3'((s + k) % 8); i_wb_data_B = N'($urandom);
          break;
        end
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin pend[r] = 0; outst[r] = 0; end
    m_err = 0; m_we_A = 0; m_rd_A = 0; m_wd_A = 0; m_we_B = 0; m_rd_B = 0; m_wd_B = 0;
    clear_inputs();
    rst = 1;
    @(negedge clk);
    step();

    // Reset state: no stall for any selectors
    clear_inputs();
    i_issue_A = 1; i_rs_re_A = 1; i_rs_A = 3'd6; i_rt_re_A = 1; i_rt_A = 3'd1;
    i_issue_B = 1; i_rs_re_B = 1; i_rs_B = 3'd4;
    #1 check("rst_stall_A", o_stall_A, 0);
    check("rst_stall_B", o_stall_B, 0);
    check("rst_we_A", o_rd_we_A, 0);
    check("rst_err", o_err, 0);
    step();

    // RAW stall with bypass release
    clear_inputs(); i_issue_A = 1; i_issue_we_A = 1; i_issue_rd_A = 3'd3; step();
    clear_inputs(); i_issue_A = 1; i_rs_re_A = 1; i_rs_A = 3'd3;
    i_wb_valid_A = 1; i_wb_rd_A = 3'd3; i_wb_data_A = 16'h1234;
    #1 check("raw_stall", o_stall_A, 1);
    step();
    clear_inputs(); i_issue_A = 1; i_rs_re_A = 1; i_rs_A = 3'd3;
    #1 check("raw_we", o_rd_we_A, 1);
    check("raw_wdata", o_wdata_A, 16'h1234);
    check("raw_bypass", o_stall_A, 0);
    step();
    clear_inputs(); i_issue_A = 1; i_rt_re_A = 1; i_rt_A = 3'd3;
    #1 check("raw_drained", o_stall_A, 0);
    step();

    // Intra-bundle dependency
    clear_inputs(); i_issue_A = 1; i_issue_we_A = 1; i_issue_rd_A = 3'd5;
    i_issue_B = 1; i_rs_re_B = 1; i_rs_B = 3'd5;
    #1 check("intra_A", o_stall_A, 0);
    check("intra_B", o_stall_B, 1);
    step();
    clear_inputs(); i_issue_A = 1; i_rs_re_A = 1; i_rs_A = 3'd5;
    i_wb_valid_B = 1; i_wb_rd_B = 3'd5; i_wb_data_B = 16'h0055;
    #1 check("intra_cnt5", o_stall_A, 1);
    step();
    clear_inputs(); step();

    // Same-rd dual issue and retire
    clear_inputs(); i_issue_A = 1; i_issue_we_A = 1; i_issue_rd_A = 3'd2;
    i_issue_B = 1; i_issue_we_B = 1; i_issue_rd_B = 3'd2;
    #1 check("dual_B", o_stall_B, 0);
    step();
    clear_inputs();
    i_wb_valid_A = 1; i_wb_rd_A = 3'd2; i_wb_data_A = 16'h0001;
    i_wb_valid_B = 1; i_wb_rd_B = 3'd2; i_wb_data_B = 16'h0002;
    step();
    clear_inputs(); i_issue_A = 1; i_rs_re_A = 1; i_rs_A = 3'd2;
    #1 check("dual_wA", o_wdata_A, 16'h0001);
    check("dual_wB", o_wdata_B, 16'h0002);
    check("dual_weB", o_rd_we_B, 1);
    step();
    clear_inputs(); i_issue_A = 1; i_rs_re_A = 1; i_rs_A = 3'd2;
    #1 check("dual_cnt0", o_stall_A, 0);
    check("dual_err", o_err, 0);
    step();

    // Saturation at 3 pending writes
    repeat (3) begin clear_inputs(); i_issue_A = 1; i_issue_we_A = 1; i_issue_rd_A = 3'd7; step(); end
    repeat (2) begin
      clear_inputs(); i_issue_A = 1; i_issue_we_A = 1; i_issue_rd_A = 3'd7;
      #1 check("sat_stall", o_stall_A, 1);
      step();
    end
    repeat (3) begin
      clear_inputs(); i_wb_valid_A = 1; i_wb_rd_A = 3'd7; i_wb_data_A = 16'h0777; step();
    end
    clear_inputs(); step();

    // Underflow: sticky until reset
    clear_inputs(); i_wb_valid_B = 1; i_wb_rd_B = 3'd1; i_wb_data_B = 16'hbeef; step();
    clear_inputs(); step();
    repeat (3) begin
      clear_inputs();
      #1 check("uflow_err", o_err, 1);
      step();
    end
    clear_inputs(); rst = 1; step();
    clear_inputs();
    #1 check("uflow_clr", o_err, 0);
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_inputs();
      gwe = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      i_issue_A = 1'($urandom); i_issue_we_A = 1'($urandom); i_issue_rd_A = 3'($urandom);
      i_rs_re_A = 1'($urandom); i_rt_re_A = 1'($urandom); i_rs_A = 3'($urandom); i_rt_A = 3'($urandom);
      i_issue_B = 1'($urandom); i_issue_we_B = 1'($urandom); i_issue_rd_B = 3'($urandom);
      i_rs_re_B = 1'($urandom); i_rt_re_B = 1'($urandom); i_rs_B = 3'($urandom); i_rt_B = 3'($urandom);
      pick_writebacks();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
